// File: rtl/ca_grid_array_if.sv
// ca_grid_array_if
//   Host row-port bundle for ca_grid_array: row write with valid/ready
//   handshake and row readback with a one-cycle registered response.
//   Parameters: WIDTH, HEIGHT, REGISTER_LENGTH (must match the array).
//   Signals:
//     wr_valid  host -> array  row write request
//     wr_ready  array -> host  write accepted when wr_valid & wr_ready
//     wr_row    host -> array  row index to write
//     wr_data   host -> array  row data, column 0 in LSBs
//     rd_req    host -> array  readback request (always accepted)
//     rd_row    host -> array  row index to read
//     rd_valid  array -> host  one-cycle pulse qualifying rd_data
//     rd_data   array -> host  row data, column 0 in LSBs
//   Modports: master = host side, slave = array side.
interface ca_grid_array_if #(
  parameter int WIDTH           = 10,
  parameter int HEIGHT          = 8,
  parameter int REGISTER_LENGTH = 8
);
  localparam int ROW_W    = $clog2(HEIGHT);
  localparam int ROW_BITS = WIDTH * REGISTER_LENGTH;

  logic                wr_valid;
  logic                wr_ready;
  logic [ROW_W-1:0]    wr_row;
  logic [ROW_BITS-1:0] wr_data;
  logic                rd_req;
  logic [ROW_W-1:0]    rd_row;
  logic                rd_valid;
  logic [ROW_BITS-1:0] rd_data;

  modport master (
    output wr_valid, wr_row, wr_data, rd_req, rd_row,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_row, wr_data, rd_req, rd_row,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/ca_grid_array.sv
// ca_grid_array
//   SIMD cellular-automaton array: a WIDTH x HEIGHT grid of cell_core
//   instances executing one broadcast instruction, each with its own state
//   register. Neighbours come from a torus wrap or, in fixed mode, from
//   boundary_value outside the grid. The host loads/reads whole rows via
//   the ca_grid_array_if port. A registered AND of all cell diverge flags
//   and a generation counter of committed steps are exported.
//   Optional feature macro: CA_GRID_CHECKSUM_EN adds a checksum output that
//   always equals the XOR of every cell state.
// Ports:
//   clk, rst (async, active-low)
//   instruction / next_program_counter / next_stack_pointer : broadcast
//   execution_enable : commit all nextstates on this edge
//   boundary_mode (0 torus, 1 fixed), boundary_value
//   host : ca_grid_array_if.slave row write/readback port
//   diverge_consensus, generation, [checksum]
//
// cell_core instruction format: [15:12] opcode, [11:8] source select,
// [7:0] immediate (replicated to REGISTER_LENGTH bits).
//   0 NOP   keep self         1 COPY  copy neighbour (sel 0 up,1 down,
//   2 LDI   load immediate            2 left,3 right, else self)
//   3 XORI  self ^ imm        4 ADDI  self + imm
//   5 SUM   up+down+left+right
//   6 CMP   keep self, diverge = (self == imm)
//   7 LDPC  folded program counter   8 LDSP  folded stack pointer
module ca_grid_array #(
  parameter int WIDTH           = 10,
  parameter int HEIGHT          = 8,
  parameter int REGISTER_LENGTH = 8,
  parameter int PC_LENGTH       = 12,
  parameter int SP_LENGTH       = 5,
  parameter int GEN_LENGTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                instruction,
  input  logic [PC_LENGTH-1:0]       next_program_counter,
  input  logic [SP_LENGTH-1:0]       next_stack_pointer,
  input  logic                       execution_enable,
  input  logic                       boundary_mode,
  input  logic [REGISTER_LENGTH-1:0] boundary_value,
  ca_grid_array_if.slave             host,
  output logic                       diverge_consensus,
  output logic [GEN_LENGTH-1:0]      generation
`ifdef CA_GRID_CHECKSUM_EN
  ,
  output logic [REGISTER_LENGTH-1:0] checksum
`endif
);
  localparam int ROW_W    = $clog2(HEIGHT);
  localparam int ROW_BITS = WIDTH * REGISTER_LENGTH;
  localparam int CELLS    = WIDTH * HEIGHT;

  logic [REGISTER_LENGTH-1:0] states_q   [HEIGHT][WIDTH];
  logic [REGISTER_LENGTH-1:0] states_d   [HEIGHT][WIDTH];
  logic [REGISTER_LENGTH-1:0] nextstates [HEIGHT][WIDTH];
  logic [CELLS-1:0]           diverge_flags;

  logic                  wr_ready_w;
  logic                  wr_fire;
  logic [ROW_BITS-1:0]   rd_row_data;

  logic [GEN_LENGTH-1:0] generation_q, generation_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ROW_BITS-1:0]   rd_data_q, rd_data_d;
  logic                  consensus_q, consensus_d;

  // Writes are only accepted on non-step cycles, so a write and a step can
  // never land on the same edge.
  assign wr_ready_w    = rst & ~execution_enable;
  assign wr_fire       = host.wr_valid & wr_ready_w;
  assign host.wr_ready = wr_ready_w;

  // Neighbour selection is static wiring plus a per-edge mux on
  // boundary_mode; only cells on the grid rim see boundary_value.
  for (genvar gy = 0; gy < HEIGHT; gy++) begin : g_row
    for (genvar gx = 0; gx < WIDTH; gx++) begin : g_col
      localparam int YU = (gy == 0)          ? HEIGHT - 1 : gy - 1;
      localparam int YD = (gy == HEIGHT - 1) ? 0          : gy + 1;
      localparam int XL = (gx == 0)          ? WIDTH - 1  : gx - 1;
      localparam int XR = (gx == WIDTH - 1)  ? 0          : gx + 1;
      localparam bit EDGE_U = (gy == 0);
      localparam bit EDGE_D = (gy == HEIGHT - 1);
      localparam bit EDGE_L = (gx == 0);
      localparam bit EDGE_R = (gx == WIDTH - 1);

      logic [REGISTER_LENGTH-1:0] n_up, n_dn, n_lf, n_rt;
      logic [REGISTER_LENGTH-1:0] ns;
      logic                       dv;

      assign n_up = (boundary_mode && EDGE_U) ? boundary_value : states_q[YU][gx];
      assign n_dn = (boundary_mode && EDGE_D) ? boundary_value : states_q[YD][gx];
      assign n_lf = (boundary_mode && EDGE_L) ? boundary_value : states_q[gy][XL];
      assign n_rt = (boundary_mode && EDGE_R) ? boundary_value : states_q[gy][XR];

      cell_core #(
        .REGISTER_LENGTH (REGISTER_LENGTH),
        .PC_LENGTH       (PC_LENGTH),
        .SP_LENGTH       (SP_LENGTH)
      ) u_cell (
        .rst             (~rst),
        .instruction     (instruction),
        .program_counter (next_program_counter),
        .stack_pointer   (next_stack_pointer),
        .i01             (n_up),
        .i21             (n_dn),
        .i10             (n_lf),
        .i12             (n_rt),
        .i11             (states_q[gy][gx]),
        .nextstate       (ns),
        .diverge         (dv)
      );

      assign nextstates[gy][gx]         = ns;
      assign diverge_flags[gy*WIDTH+gx] = dv;
    end
  end

  // Readback mux; an out-of-range row yields zero.
  always_comb begin
    rd_row_data = '0;
    for (int y = 0; y < HEIGHT; y++) begin
      if (host.rd_row == ROW_W'(y)) begin
        for (int x = 0; x < WIDTH; x++) begin
          rd_row_data[x*REGISTER_LENGTH +: REGISTER_LENGTH] = states_q[y][x];
        end
      end
    end
  end

  // An out-of-range write row matches no row: handshake completes, data dropped.
  always_comb begin
    for (int y = 0; y < HEIGHT; y++) begin
      for (int x = 0; x < WIDTH; x++) begin
        states_d[y][x] = states_q[y][x];
      end
    end
    if (execution_enable) begin
      for (int y = 0; y < HEIGHT; y++) begin
        for (int x = 0; x < WIDTH; x++) begin
          states_d[y][x] = nextstates[y][x];
        end
      end
    end else if (wr_fire) begin
      for (int y = 0; y < HEIGHT; y++) begin
        if (host.wr_row == ROW_W'(y)) begin
          for (int x = 0; x < WIDTH; x++) begin
            states_d[y][x] = host.wr_data[x*REGISTER_LENGTH +: REGISTER_LENGTH];
          end
        end
      end
    end
  end

  // rd_data captures pre-edge state and holds while no request is pending.
  always_comb begin
    generation_d = generation_q;
    if (execution_enable) begin
      generation_d = generation_q + GEN_LENGTH'(1);
    end
    rd_valid_d  = host.rd_req;
    rd_data_d   = host.rd_req ? rd_row_data : rd_data_q;
    consensus_d = &diverge_flags;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int y = 0; y < HEIGHT; y++) begin
        for (int x = 0; x < WIDTH; x++) begin
          states_q[y][x] <= '0;
        end
      end
      generation_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      consensus_q  <= 1'b0;
    end else begin
      for (int y = 0; y < HEIGHT; y++) begin
        for (int x = 0; x < WIDTH; x++) begin
          states_q[y][x] <= states_d[y][x];
        end
      end
      generation_q <= generation_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      consensus_q  <= consensus_d;
    end
  end

  assign host.rd_valid     = rd_valid_q;
  assign host.rd_data      = rd_data_q;
  assign diverge_consensus = consensus_q;
  assign generation        = generation_q;

`ifdef CA_GRID_CHECKSUM_EN
  logic [REGISTER_LENGTH-1:0] checksum_q, checksum_d;
  logic [REGISTER_LENGTH-1:0] xor_next, xor_old, xor_new;
  logic                       wr_hit;

  // Incremental update on writes keeps checksum equal to XOR of all states
  // without a full-grid reduction on every write.
  always_comb begin
    xor_next = '0;
    for (int y = 0; y < HEIGHT; y++) begin
      for (int x = 0; x < WIDTH; x++) begin
        xor_next = xor_next ^ nextstates[y][x];
      end
    end
    xor_new = '0;
    for (int x = 0; x < WIDTH; x++) begin
      xor_new = xor_new ^ host.wr_data[x*REGISTER_LENGTH +: REGISTER_LENGTH];
    end
    xor_old = '0;
    wr_hit  = 1'b0;
    for (int y = 0; y < HEIGHT; y++) begin
      if (host.wr_row == ROW_W'(y)) begin
        wr_hit = 1'b1;
        for (int x = 0; x < WIDTH; x++) begin
          xor_old = xor_old ^ states_q[y][x];
        end
      end
    end
    checksum_d = checksum_q;
    if (execution_enable) begin
      checksum_d = xor_next;
    end else if (wr_fire && wr_hit) begin
      checksum_d = checksum_q ^ xor_old ^ xor_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif
endmodule

// cell_core
//   Combinational per-cell execution unit. Computes the cell's next state
//   and diverge flag from the broadcast instruction and its five
//   neighbourhood values. Outputs are forced to zero while rst is high.
// Ports: rst (active-high), instruction, program_counter, stack_pointer,
//   i01 up, i21 down, i10 left, i12 right, i11 self, nextstate, diverge.
module cell_core #(
  parameter int REGISTER_LENGTH = 8,
  parameter int PC_LENGTH       = 12,
  parameter int SP_LENGTH       = 5
) (
  input  logic                       rst,
  input  logic [15:0]                instruction,
  input  logic [PC_LENGTH-1:0]       program_counter,
  input  logic [SP_LENGTH-1:0]       stack_pointer,
  input  logic [REGISTER_LENGTH-1:0] i01,
  input  logic [REGISTER_LENGTH-1:0] i21,
  input  logic [REGISTER_LENGTH-1:0] i10,
  input  logic [REGISTER_LENGTH-1:0] i12,
  input  logic [REGISTER_LENGTH-1:0] i11,
  output logic [REGISTER_LENGTH-1:0] nextstate,
  output logic                       diverge
);
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_COPY = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_XORI = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_SUM  = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'h6;
  localparam logic [3:0] OP_LDPC = 4'h7;
  localparam logic [3:0] OP_LDSP = 4'h8;

  logic [3:0]                 opcode;
  logic [3:0]                 sel;
  logic [REGISTER_LENGTH-1:0] imm;
  logic [REGISTER_LENGTH-1:0] pc_fold;
  logic [REGISTER_LENGTH-1:0] sp_fold;
  logic [REGISTER_LENGTH-1:0] src;

  assign opcode = instruction[15:12];
  assign sel    = instruction[11:8];

  // PC/SP are folded by XOR so every bit reaches the register regardless
  // of relative widths.
  always_comb begin
    imm     = '0;
    pc_fold = '0;
    sp_fold = '0;
    for (int i = 0; i < REGISTER_LENGTH; i++) begin
      imm[i] = instruction[i % 8];
    end
    for (int i = 0; i < PC_LENGTH; i++) begin
      pc_fold[i % REGISTER_LENGTH] = pc_fold[i % REGISTER_LENGTH] ^ program_counter[i];
    end
    for (int i = 0; i < SP_LENGTH; i++) begin
      sp_fold[i % REGISTER_LENGTH] = sp_fold[i % REGISTER_LENGTH] ^ stack_pointer[i];
    end
  end

  always_comb begin
    case (sel)
      4'd0:    src = i01;
      4'd1:    src = i21;
      4'd2:    src = i10;
      4'd3:    src = i12;
      default: src = i11;
    endcase
  end

  always_comb begin
    nextstate = i11;
    diverge   = 1'b0;
    case (opcode)
      OP_NOP:  nextstate = i11;
      OP_COPY: nextstate = src;
      OP_LDI:  nextstate = imm;
      OP_XORI: nextstate = i11 ^ imm;
      OP_ADDI: nextstate = i11 + imm;
      OP_SUM:  nextstate = i01 + i21 + i10 + i12;
      OP_CMP:  diverge   = (i11 == imm);
      OP_LDPC: nextstate = pc_fold;
      OP_LDSP: nextstate = sp_fold;
      default: nextstate = i11;
    endcase
    if (rst) begin
      nextstate = '0;
      diverge   = 1'b0;
    end
  end
endmodule
